gpu_buffer_engine: RTL and testbench
====================================

// Module: gpu_buffer_engine
// PURPOSE
//  Hardware clear/scroll sequencer for the character buffer's CPU-side port (clk_cpu domain).
//  Executes clear_screen/scroll_screen pulses from gpu_registers without CPU copy loops.
//  Shares the single buffer port between CPU character writes and the engine; CPU always wins.
//  Sits between gpu_registers and character_buffer inside gpu_core.
// PARAMETERS
//  ADDR_W     12     buffer address width
//  ROWS       30     text rows
//  FILL_CHAR  8'h20  code written by clear and into the vacated bottom row
// PORTS
//  clk           in   1       CPU/system clock (the only clock)
//  rst           in   1       asynchronous, active-high reset
//  mode_80col    in   1       0=40 cols, 1=80 cols; sampled only at command start
//  clear_start   in   1       1-cycle clear command pulse
//  scroll_start  in   1       1-cycle scroll-up-one-row command pulse
//  cpu_addr      in   ADDR_W  CPU write address (from gpu_registers)
//  cpu_wdata     in   8       CPU write data
//  cpu_we        in   1       CPU write strobe
//  buf_addr      out  ADDR_W  buffer port address
//  buf_wdata     out  8       buffer port write data
//  buf_we        out  1       buffer port write enable
//  buf_re        out  1       buffer port read enable
//  buf_rdata     in   8       buffer read data, valid the cycle after buf_re
//  busy          out  1       command in progress
//  done          out  1       1-cycle pulse on command completion
// BEHAVIOUR
//  - Reset (async): state IDLE, ptr 0, busy=0, done=0; no engine access; buffer contents are untouched.
//  - buf_* is a combinational mux: if cpu_we, the CPU path drives it (buf_re=0). Otherwise the engine's registered request drives it.
//  - An engine access is granted only in cycles with cpu_we=0; on a lost cycle the engine holds its state and pointer.
//  - cols = mode_80col ? 80 : 40, latched at start; N = ROWS*cols; ptr width ADDR_W; no wrap (N <= 2400).
//  - FSM: IDLE, CLEAR, SCR_RD, SCR_WR, SCR_FILL.
//  - Start rules: in IDLE, clear_start wins over a simultaneous scroll_start. Start pulses while busy are ignored.
//  - busy goes high the cycle after the start pulse.
//  - CLEAR: each granted cycle writes FILL_CHAR at ptr and increments ptr. After ptr=N-1: done=1, busy=0 next cycle.
//  - Scroll copy, for dst = 0 .. N-cols-1:
//    - SCR_RD: buf_re at dst+cols.
//    - SCR_WR: capture buf_rdata into rdata_q on the cycle after the read grant (unconditionally); write rdata_q at dst on the next grant.
//    - A CPU steal between read and write does not lose data.
//  - SCR_FILL: writes FILL_CHAR at N-cols .. N-1, then done.
//  - Nominal busy time with no CPU traffic:
//    - clear: N cycles.
//    - scroll: 2*(N-cols)+cols cycles.
//  - done is high for exactly one cycle, in the same cycle busy drops. It never asserts without a prior start.
//  - CPU writes during busy are performed immediately. Ordering against engine writes is undefined; software polls busy first.
//  - Reset asserted mid-command aborts at once with no done pulse; the buffer is left partially processed.
// CONFIGURATION
//  GPU_SCROLL_EN defined: full behaviour above.
//  GPU_SCROLL_EN undefined: SCR_* states are not built. scroll_start is ignored (no busy, no done) and buf_re is tied 0.
// STRUCTURE
//  Package gpu_pkg: state encoding constants, COLS_40/COLS_80, ROWS, FILL_CHAR default, ADDR_W.
//  One sub-module, gpu_buf_arbiter: combinational CPU-priority mux that produces buf_* and the engine grant.
// TESTING
//  1. 40-col, clear_start, no CPU traffic -> busy high 1200 cycles; addrs 0..1199 written with 8'h20; one done pulse.
//  2. 80-col buffer with cell[k] = k[7:0], scroll_start -> cell[0..2319] = old cell[80..2399]; cell[2320..2399] = 8'h20; busy 4720 cycles.
//  3. cpu_we asserted every 3rd cycle during a 40-col scroll -> each CPU write lands on the same cycle; final copy correct; busy extends by the steal count.
//  4. clear_start and scroll_start asserted together, then scroll_start again mid-clear -> only the clear runs; exactly one done.
//  5. rst pulsed at cycle 500 of a clear -> busy=0 and done=0 immediately; cells 0..~499 = 8'h20, the rest unchanged; a new clear then works.
//  6. GPU_SCROLL_EN undefined, scroll_start -> busy stays 0; no buf_we; no done.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared constants and the state encoding for the character-buffer clear/scroll engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gpu_pkg;

    localparam int       GPU_ADDR_W    = 12;
    localparam int       GPU_ROWS      = 30;
    localparam int       COLS_40       = 40;
    localparam int       COLS_80       = 80;
    localparam bit [7:0] GPU_FILL_CHAR = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLEAR    = 3'd1,
        ST_SCR_RD   = 3'd2,
        ST_SCR_WR   = 3'd3,
        ST_SCR_FILL = 3'd4
    } eng_state_e;

endpackage

// File: rtl/gpu_buffer_engine_if.sv
// Character-buffer port bundle: CPU write request in, shared buffer port out, read data back.
// Latency: n/a (wires only); buf_rdata is valid the cycle after buf_re.
// Backpressure: none in the bundle itself; the CPU path always owns the port when cpu_we is high.
//   master : CPU side + buffer model (drives cpu_*, buf_rdata)
//   slave  : the engine (drives buf_addr/buf_wdata/buf_we/buf_re)
interface gpu_buffer_engine_if #(
    parameter int ADDR_W = gpu_pkg::GPU_ADDR_W
);
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic              cpu_we;
    logic [ADDR_W-1:0] buf_addr;
    logic [7:0]        buf_wdata;
    logic              buf_we;
    logic              buf_re;
    logic [7:0]        buf_rdata;

    modport master (
        output cpu_addr, cpu_wdata, cpu_we, buf_rdata,
        input  buf_addr, buf_wdata, buf_we, buf_re
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_we, buf_rdata,
        output buf_addr, buf_wdata, buf_we, buf_re
    );
endinterface

// File: rtl/gpu_buf_arbiter.sv
// CPU-priority mux for the single buffer port; also produces the engine grant.
// Latency: purely combinational.
// Backpressure: the engine is stalled (eng_gnt_o=0) in every cycle the CPU writes.
//   in : cpu_we_i/cpu_addr_i/cpu_wdata_i, eng_we_i/eng_re_i/eng_addr_i/eng_wdata_i
//   out: buf_addr_o/buf_wdata_o/buf_we_o/buf_re_o, eng_gnt_o
module gpu_buf_arbiter #(
    parameter int ADDR_W = 12
) (
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [7:0]        cpu_wdata_i,
    input  logic              eng_we_i,
    input  logic              eng_re_i,
    input  logic [ADDR_W-1:0] eng_addr_i,
    input  logic [7:0]        eng_wdata_i,
    output logic [ADDR_W-1:0] buf_addr_o,
    output logic [7:0]        buf_wdata_o,
    output logic              buf_we_o,
    output logic              buf_re_o,
    output logic              eng_gnt_o
);

    always_comb begin
        if (cpu_we_i) begin
            buf_addr_o  = cpu_addr_i;
            buf_wdata_o = cpu_wdata_i;
            buf_we_o    = 1'b1;
            buf_re_o    = 1'b0;
        end else begin
            buf_addr_o  = eng_addr_i;
            buf_wdata_o = eng_wdata_i;
            buf_we_o    = eng_we_i;
            buf_re_o    = eng_re_i;
        end
    end

    assign eng_gnt_o = ~cpu_we_i & (eng_we_i | eng_re_i);

endmodule

// File: rtl/gpu_buffer_engine.sv
// Clear / scroll-up-one-row sequencer sharing the character buffer's CPU port.
// Latency: busy the cycle after a start pulse; clear N cycles, scroll 2*(N-cols)+cols cycles when unstalled.
// Backpressure: any CPU write cycle stalls the engine, which holds state and pointer.
//   Ports: clk, rst (async active-high), mode_80col, clear_start, scroll_start,
//          bus (slave modport: cpu_* in, buf_* out, buf_rdata in), busy, done.
//   Build option: define GPU_SCROLL_EN to build the scroll states; otherwise
//          scroll_start is ignored and buf_re is never asserted.
module gpu_buffer_engine
    import gpu_pkg::*;
#(
    parameter int       ADDR_W    = GPU_ADDR_W,
    parameter int       ROWS      = GPU_ROWS,
    parameter bit [7:0] FILL_CHAR = GPU_FILL_CHAR
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mode_80col,
    input  logic                clear_start,
    input  logic                scroll_start,
    gpu_buffer_engine_if.slave  bus,
    output logic                busy,
    output logic                done
);

    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    eng_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] cols_q, cols_d;
    logic              done_q, done_d;

    logic [ADDR_W-1:0] start_cols;
    logic [ADDR_W-1:0] n_w;
    logic [ADDR_W-1:0] last_w;

    logic              eng_we, eng_re, eng_gnt;
    logic [ADDR_W-1:0] eng_addr;
    logic [7:0]        eng_wdata;

    assign start_cols = mode_80col ? ADDR_W'(COLS_80) : ADDR_W'(COLS_40);
    assign n_w        = ADDR_W'(ROWS) * cols_q;
    assign last_w     = n_w - PTR_ONE;

`ifdef GPU_SCROLL_EN
    logic [7:0]        rdata_q;
    logic              rd_pend_q;
    logic [ADDR_W-1:0] copy_last_w;
    logic [ADDR_W-1:0] fill_base_w;

    assign copy_last_w = n_w - cols_q - PTR_ONE;
    assign fill_base_w = n_w - cols_q;

    // rd_pend_q marks the cycle in which buf_rdata holds the word just read;
    // it is captured then whether or not the write is granted that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            rd_pend_q <= eng_re & eng_gnt;
            if (rd_pend_q) begin
                rdata_q <= bus.buf_rdata;
            end
        end
    end
`else
    logic unused_scroll;
    assign unused_scroll = scroll_start ^ (^bus.buf_rdata);
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cols_q  <= ADDR_W'(COLS_40);
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cols_q  <= cols_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; start pulses are only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cols_d  = cols_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear_start) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                    cols_d  = start_cols;
                end
`ifdef GPU_SCROLL_EN
                else if (scroll_start) begin
                    state_d = ST_SCR_RD;
                    ptr_d   = '0;
                    cols_d  = start_cols;
                end
`endif
            end
            ST_CLEAR: begin
                if (eng_gnt) begin
                    if (ptr_q == last_w) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        ptr_d = ptr_q + PTR_ONE;
                    end
                end
            end
`ifdef GPU_SCROLL_EN
            ST_SCR_RD: begin
                if (eng_gnt) begin
                    state_d = ST_SCR_WR;
                end
            end
            ST_SCR_WR: begin
                if (eng_gnt) begin
                    if (ptr_q == copy_last_w) begin
                        state_d = ST_SCR_FILL;
                        ptr_d   = fill_base_w;
                    end else begin
                        state_d = ST_SCR_RD;
                        ptr_d   = ptr_q + PTR_ONE;
                    end
                end
            end
            ST_SCR_FILL: begin
                if (eng_gnt) begin
                    if (ptr_q == last_w) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        ptr_d = ptr_q + PTR_ONE;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Engine request, decoded from the registered state and pointer.
    always_comb begin
        eng_we    = 1'b0;
        eng_re    = 1'b0;
        eng_addr  = ptr_q;
        eng_wdata = FILL_CHAR;
        case (state_q)
            ST_CLEAR: eng_we = 1'b1;
`ifdef GPU_SCROLL_EN
            ST_SCR_RD: begin
                eng_re   = 1'b1;
                eng_addr = ptr_q + cols_q;
            end
            ST_SCR_WR: begin
                eng_we    = 1'b1;
                // First write cycle forwards the read word directly so a copy
                // costs two cycles; after a steal the captured copy is used.
                eng_wdata = rd_pend_q ? bus.buf_rdata : rdata_q;
            end
            ST_SCR_FILL: eng_we = 1'b1;
`endif
            default: ;
        endcase
    end

    gpu_buf_arbiter #(.ADDR_W(ADDR_W)) u_arb (
        .cpu_we_i    (bus.cpu_we),
        .cpu_addr_i  (bus.cpu_addr),
        .cpu_wdata_i (bus.cpu_wdata),
        .eng_we_i    (eng_we),
        .eng_re_i    (eng_re),
        .eng_addr_i  (eng_addr),
        .eng_wdata_i (eng_wdata),
        .buf_addr_o  (bus.buf_addr),
        .buf_wdata_o (bus.buf_wdata),
        .buf_we_o    (bus.buf_we),
        .buf_re_o    (bus.buf_re),
        .eng_gnt_o   (eng_gnt)
    );

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_gpu_buffer_engine.sv
// Randomized scoreboard bench for gpu_buffer_engine with a behavioural buffer RAM.
// Latency: n/a.
// Backpressure: CPU write cycles are injected to stall the engine.
module tb_gpu_buffer_engine;
    import gpu_pkg::*;

    localparam int AW = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mode_80col = 1'b0;
    logic clear_start = 1'b0;
    logic scroll_start = 1'b0;
    logic busy, done;

    gpu_buffer_engine_if #(.ADDR_W(AW)) bus();

    gpu_buffer_engine dut (
        .clk          (clk),
        .rst          (rst),
        .mode_80col   (mode_80col),
        .clear_start  (clear_start),
        .scroll_start (scroll_start),
        .bus          (bus),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Character buffer: synchronous write, one-cycle read latency.
    bit [7:0] ram [4096];
    always @(posedge clk) begin
        if (bus.buf_we) ram[bus.buf_addr] <= bus.buf_wdata;
        if (bus.buf_re) bus.buf_rdata <= ram[bus.buf_addr];
    end

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    wr_t      wq[$];          // expected engine writes, in order
    int       dq[$];          // expected busy length per completed command
    bit [7:0] ref_mem [4096]; // expected buffer contents
    bit       steal_pat [16384];
    int       checks = 0;
    int       errors = 0;
    int       eng_wr_cnt = 0;
    int       busy_len = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle, away from the active edge.
    initial begin : monitor
        wr_t e;
        int  exp_len;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_len = 0;
            end else begin
                if (bus.cpu_we) begin
                    chk("cpu_passthru",
                        int'({bus.buf_we, bus.buf_re, bus.buf_addr, bus.buf_wdata}),
                        int'({1'b1, 1'b0, bus.cpu_addr, bus.cpu_wdata}));
                end else if (bus.buf_we) begin
                    if (wq.size() == 0) begin
                        chk("extra_eng_write_addr", int'(bus.buf_addr), -1);
                    end else begin
                        e = wq.pop_front();
                        chk("eng_write", int'({bus.buf_addr, bus.buf_wdata}), int'({e.addr, e.data}));
                        ref_mem[e.addr] = e.data;
                        eng_wr_cnt++;
                    end
                end
                if (done) begin
                    if (dq.size() == 0) begin
                        chk("unexpected_done", int'(done), 0);
                    end else begin
                        exp_len = dq.pop_front();
                        chk("busy_len", busy_len, exp_len);
                        chk("busy_at_done", int'(busy), 0);
                    end
                end
                if (busy) busy_len++;
                else      busy_len = 0;
            end
        end
    end

    task automatic cpu_write(input int a, input bit [7:0] d);
        bus.cpu_addr  = AW'(a);
        bus.cpu_wdata = d;
        bus.cpu_we    = 1'b1;
        ref_mem[a]    = d;
        tick();
        bus.cpu_we    = 1'b0;
    endtask

    task automatic preload(input int lo, input int hi, input bit ramp);
        for (int a = lo; a <= hi; a++) begin
            if (ramp) cpu_write(a, 8'(a));
            else      cpu_write(a, 8'($urandom));
        end
    endtask

    task automatic mem_check(input string name);
        int bad;
        bad = -1;
        for (int a = 0; a < 4096; a++) begin
            if (ram[a] != ref_mem[a] && bad < 0) bad = a;
        end
        chk(name, bad, -1);
    endtask

    // steal_mode: 0 none, 3 every third cycle, 1 random ~25%.
    task automatic run_cmd(input bit clr, input bit scr, input bit m80,
                           input int steal_mode, input int abort_at, input int rescroll_at);
        int cols, n, nominal, rem, k, a;
        cols = m80 ? 80 : 40;
        n    = 30 * cols;
        for (int c = 0; c < 16384; c++) begin
            if (steal_mode == 3)      steal_pat[c] = (c % 3 == 0);
            else if (steal_mode == 1) steal_pat[c] = ($urandom_range(0, 3) == 0);
            else                      steal_pat[c] = 1'b0;
        end
        steal_pat[0] = 1'b0;
        nominal = 0;
        if (clr) begin
            for (int d = 0; d < n; d++) wq.push_back('{addr: AW'(d), data: 8'h20});
            nominal = n;
        end
`ifdef GPU_SCROLL_EN
        else if (scr) begin
            for (int d = 0; d < n - cols; d++) wq.push_back('{addr: AW'(d), data: ref_mem[d + cols]});
            for (int d = n - cols; d < n; d++) wq.push_back('{addr: AW'(d), data: 8'h20});
            nominal = 2 * (n - cols) + cols;
        end
`endif
        // Busy cycles: every non-stolen cycle retires one unit of work.
        rem = nominal;
        k   = 1;
        while (rem > 0) begin
            if (!steal_pat[k]) rem--;
            k++;
        end
        if (nominal > 0 && abort_at == 0) dq.push_back(k - 1);
        eng_wr_cnt   = 0;
        mode_80col   = m80;
        clear_start  = clr;
        scroll_start = scr;
        tick();
        clear_start  = 1'b0;
        scroll_start = 1'b0;
        mode_80col   = 1'($urandom_range(0, 1));
        for (int c = 1; c <= k + 1; c++) begin
            if (nominal == 0) chk("ignored_busy_re", int'({busy, bus.buf_re, done}), 0);
            if (steal_pat[c]) begin
                a = $urandom_range(2400, 4095);
                bus.cpu_addr  = AW'(a);
                bus.cpu_wdata = 8'($urandom);
                bus.cpu_we    = 1'b1;
                ref_mem[a]    = bus.cpu_wdata;
            end
            if (c == rescroll_at) scroll_start = 1'b1;
            if (c == abort_at) begin
                rst = 1'b1;
                #1;
                chk("abort_busy", int'(busy), 0);
                chk("abort_done", int'(done), 0);
                chk("abort_writes", eng_wr_cnt, abort_at - 1);
                wq.delete();
                dq.delete();
                bus.cpu_we   = 1'b0;
                scroll_start = 1'b0;
                tick();
                tick();
                rst = 1'b0;
                tick();
                break;
            end
            tick();
            bus.cpu_we   = 1'b0;
            scroll_start = 1'b0;
        end
        if (abort_at == 0) begin
            chk("writes_pending", wq.size(), 0);
            chk("done_pending", dq.size(), 0);
        end
        wq.delete();
        dq.delete();
    endtask

    initial begin : main
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.cpu_we    = 1'b0;
        tick();
        tick();
        chk("reset_outputs", int'({busy, done, bus.buf_we, bus.buf_re}), 0);
        rst = 1'b0;
        tick();
        chk("post_reset_idle", int'({busy, done}), 0);

        // 40-col clear, no CPU traffic
        preload(0, 1199, 1'b0);
        run_cmd(1'b1, 1'b0, 1'b0, 0, 0, 0);
        mem_check("mem_clear40");

        // 80-col scroll of a ramp pattern
        preload(0, 2399, 1'b1);
        run_cmd(1'b0, 1'b1, 1'b1, 0, 0, 0);
        mem_check("mem_scroll80");

        // 40-col scroll with a CPU write every third cycle
        preload(0, 1199, 1'b0);
        run_cmd(1'b0, 1'b1, 1'b0, 3, 0, 0);
        mem_check("mem_scroll40_steal");

        // Simultaneous starts, then a scroll pulse mid-clear
        run_cmd(1'b1, 1'b1, 1'b1, 1, 0, 300);
        repeat (10) begin
            chk("after_cmd_idle", int'({busy, done}), 0);
            tick();
        end
        mem_check("mem_clear80_prio");

        // Reset in the middle of a clear, then a fresh clear
        preload(0, 1199, 1'b0);
        run_cmd(1'b1, 1'b0, 1'b0, 0, 500, 0);
        mem_check("mem_abort");
        run_cmd(1'b1, 1'b0, 1'b0, 0, 0, 0);
        mem_check("mem_clear_after_abort");

        // Scroll with random CPU traffic (ignored when scroll is not built)
        preload(0, 1199, 1'b0);
        run_cmd(1'b0, 1'b1, 1'b0, 1, 0, 0);
        mem_check("mem_scroll40_rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
